// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types for the program-counter sequencer:
//   state_e : run state of the sequencer (IDLE -> RUN -> HALT)
//   sel_e   : which source feeds next_pc this cycle
// Default sizing constants are provided for instantiating code.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  localparam int PC_AW_DEF        = 4;
  localparam int PC_RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,  // next_pc = pc
    SEL_RET  = 3'd1,  // next_pc = return-address-stack top
    SEL_TGT  = 3'd2,  // next_pc = target_addr
    SEL_BR   = 3'd3,  // next_pc = pc + signed branch_off
    SEL_SEQ  = 3'd4   // next_pc = pc + 1
  } sel_e;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the control/flag inputs and the next-address outputs of the
// program-counter sequencer.
//   master : drives start/pc/stall/halt/branch/jump/call/ret/target,
//            observes next_pc/running/ras_err (decode + PC register side)
//   slave  : the sequencer itself
// Parameter AW : address width.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int AW = 4
);

  logic          start;
  logic [AW-1:0] pc;
  logic          stall;
  logic          halt;
  logic          branch_en;
  logic [AW-1:0] branch_off;
  logic          jump_en;
  logic          call_en;
  logic          ret_en;
  logic [AW-1:0] target_addr;
  logic [AW-1:0] next_pc;
  logic          running;
  logic          ras_err;

  modport master (
    output start, pc, stall, halt, branch_en, branch_off,
           jump_en, call_en, ret_en, target_addr,
    input  next_pc, running, ras_err
  );

  modport slave (
    input  start, pc, stall, halt, branch_en, branch_off,
           jump_en, call_en, ret_en, target_addr,
    output next_pc, running, ras_err
  );

endinterface : pc_sequencer_if

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Return-address stack: LIFO of DEPTH entries, AW bits each.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the stack)
//   push       : write push_data on top (ignored when full)
//   pop        : remove top entry (ignored when empty)
//   push_data  : value pushed
//   top        : current top entry (valid only when !empty)
//   full/empty : occupancy flags
// The caller never asserts push and pop together.
// -----------------------------------------------------------------------------
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [AW-1:0] mem_q [DEPTH];

  // ptr counts valid entries; slot ptr-1 holds the top.
  assign full   = (ptr_q == PW'(DEPTH));
  assign empty  = (ptr_q == '0);
  assign wr_idx = IW'(ptr_q);
  assign rd_idx = IW'(ptr_q - PW'(1));
  assign top    = mem_q[rd_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is carried
  // entirely by ptr_q, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule : pc_ras

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Next-address controller for the program counter. Each cycle it selects
// next_pc from hold / return / target / branch / sequential sources and
// sequences the run state IDLE -> RUN -> HALT (HALT exits only via rst).
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : pc_sequencer_if.slave
//          in : start, pc, stall, halt, branch_en, branch_off (signed),
//               jump_en, call_en, ret_en, target_addr
//          out: next_pc (combinational), running (registered),
//               ras_err (sticky, registered)
//
// Build option:
//   PC_RAS_EN defined   : call pushes pc+1 onto a RAS_DEPTH-entry return
//                         stack, ret pops it; over/underflow sets ras_err.
//   PC_RAS_EN undefined : no stack; call acts as jump, ret is ignored,
//                         ras_err is tied 0.
// Priority in RUN without stall: halt > ret > call > jump > branch > seq.
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int AW        = PC_AW_DEF,
  parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);

  state_e        state_q, state_d;
  logic          running_q, running_d;
  sel_e          sel;
  logic [AW-1:0] next_pc;

`ifdef PC_RAS_EN
  logic          ras_push, ras_pop;
  logic          ras_full, ras_empty;
  logic [AW-1:0] ras_top;
  logic          err_set;
  logic          ras_err_q, ras_err_d;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (bus.pc + AW'(1)),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`else
  // Depth and ret_en have no function without the stack.
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ret;
  assign unused_ret = bus.ret_en;
`endif

  // Next-state / source-select logic.
  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
`ifdef PC_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    err_set  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A stalled cycle holds everything, including a pending halt.
        if (!bus.stall) begin
          if (bus.halt) begin
            state_d = HALT;
            sel     = SEL_HOLD;
          end
`ifdef PC_RAS_EN
          else if (bus.ret_en) begin
            if (ras_empty) begin
              sel     = SEL_SEQ;  // underflow: fall through to pc+1
              err_set = 1'b1;
            end else begin
              sel     = SEL_RET;
              ras_pop = 1'b1;
            end
          end else if (bus.call_en) begin
            sel = SEL_TGT;        // overflow still jumps, return is lost
            if (ras_full) begin
              err_set = 1'b1;
            end else begin
              ras_push = 1'b1;
            end
          end else if (bus.jump_en) begin
            sel = SEL_TGT;
          end
`else
          else if (bus.call_en || bus.jump_en) begin
            sel = SEL_TGT;
          end
`endif
          else if (bus.branch_en) begin
            sel = SEL_BR;
          end else begin
            sel = SEL_SEQ;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Source mux; all sums wrap modulo 2^AW.
  always_comb begin
    next_pc = bus.pc;
    unique case (sel)
      SEL_HOLD: next_pc = bus.pc;
`ifdef PC_RAS_EN
      SEL_RET:  next_pc = ras_top;
`endif
      SEL_TGT:  next_pc = bus.target_addr;
      SEL_BR:   next_pc = bus.pc + bus.branch_off;
      SEL_SEQ:  next_pc = bus.pc + AW'(1);
      default:  next_pc = bus.pc;
    endcase
  end

  assign running_d = (state_d == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
    end
  end

`ifdef PC_RAS_EN
  assign ras_err_d = ras_err_q | err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= ras_err_d;
    end
  end

  assign bus.ras_err = ras_err_q;
`else
  assign bus.ras_err = 1'b0;
`endif

  assign bus.next_pc = next_pc;
  assign bus.running = running_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. A reference model holds the run state
// as an integer, the return stack as a queue and computes next_pc with plain
// modulo arithmetic. Works with or without PC_RAS_EN.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int M     = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_sequencer_if #(.AW(AW)) bus ();

  pc_sequencer #(
    .AW        (AW),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 = idle, 1 = run, 2 = halted.
  int mstate = 0;
  int ras[$];
  bit merr = 1'b0;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.start       = 1'b0;
    bus.pc          = '0;
    bus.stall       = 1'b0;
    bus.halt        = 1'b0;
    bus.branch_en   = 1'b0;
    bus.branch_off  = '0;
    bus.jump_en     = 1'b0;
    bus.call_en     = 1'b0;
    bus.ret_en      = 1'b0;
    bus.target_addr = '0;
  endtask

  // Called just after a rising edge with inputs already applied: checks the
  // combinational next_pc, crosses one edge, checks registered outputs.
  task automatic cyc(string tag);
    int exp_pc, nstate, pcv, off;
    #1;
    pcv    = int'(bus.pc);
    exp_pc = pcv;
    nstate = mstate;
    if (rst) begin
      nstate = 0;
      ras.delete();
      merr = 1'b0;
    end else if (mstate == 0) begin
      if (bus.start) nstate = 1;
    end else if (mstate == 1 && !bus.stall) begin
      if (bus.halt) begin
        nstate = 2;
      end
`ifdef PC_RAS_EN
      else if (bus.ret_en) begin
        if (ras.size() == 0) begin
          exp_pc = (pcv + 1) % M;
          merr   = 1'b1;
        end else begin
          exp_pc = ras.pop_back();
        end
      end else if (bus.call_en) begin
        exp_pc = int'(bus.target_addr);
        if (ras.size() == DEPTH) merr = 1'b1;
        else ras.push_back((pcv + 1) % M);
      end else if (bus.jump_en) begin
        exp_pc = int'(bus.target_addr);
      end
`else
      else if (bus.call_en || bus.jump_en) begin
        exp_pc = int'(bus.target_addr);
      end
`endif
      else if (bus.branch_en) begin
        off = int'(bus.branch_off);
        if (off >= M / 2) off -= M;
        exp_pc = ((pcv + off) % M + M) % M;
      end else begin
        exp_pc = (pcv + 1) % M;
      end
    end
    check({tag, "/next_pc"}, 8'(bus.next_pc), 8'(exp_pc));
    @(posedge clk);
    mstate = nstate;
    #1;
    check({tag, "/running"}, 8'(bus.running), 8'(mstate == 1));
    check({tag, "/ras_err"}, 8'(bus.ras_err), 8'(merr));
  endtask

  task automatic async_reset(string tag);
    rst = 1'b1;
    #2;
    ras.delete();
    merr   = 1'b0;
    mstate = 0;
    check({tag, "/running"}, 8'(bus.running), 8'(0));
    check({tag, "/ras_err"}, 8'(bus.ras_err), 8'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b1;
    // Reset held for three cycles, pc = 0, start = 0.
    for (int i = 0; i < 3; i++) cyc("reset");
    rst = 1'b0;
    cyc("idle");

    bus.start = 1'b1;
    cyc("start");
    clr();

    // Wrap of the sequential increment and a negative branch.
    bus.pc = 4'hF;
    cyc("seq_wrap");
    bus.pc = 4'h1; bus.branch_en = 1'b1; bus.branch_off = 4'hE;
    cyc("branch_neg");
    clr();

    // Jump beats branch; stall overrides both.
    bus.pc = 4'h3; bus.jump_en = 1'b1; bus.branch_en = 1'b1; bus.target_addr = 4'h9;
    cyc("jump_over_branch");
    bus.stall = 1'b1;
    cyc("stall_hold");
    clr();

    // Call then return.
    bus.pc = 4'h2; bus.call_en = 1'b1; bus.target_addr = 4'h8;
    cyc("call");
    clr();
    bus.pc = 4'h8; bus.ret_en = 1'b1;
    cyc("ret");
    clr();
    // ret beats call in the same cycle.
    bus.pc = 4'h6; bus.ret_en = 1'b1; bus.call_en = 1'b1; bus.target_addr = 4'hA;
    cyc("ret_vs_call");
    clr();

    // Five nested calls against a four-deep stack.
    for (int i = 0; i < 5; i++) begin
      bus.pc = 4'(i * 3); bus.call_en = 1'b1; bus.target_addr = 4'(i + 10);
      cyc($sformatf("nest%0d", i));
    end
    clr();
    for (int i = 0; i < 2; i++) begin
      bus.pc = 4'hC; bus.ret_en = 1'b1;
      cyc($sformatf("unwind%0d", i));
    end
    clr();

    // Asynchronous reset mid-run, then restart.
    async_reset("mid_rst");
    bus.pc = 4'h5;
    cyc("post_rst_idle");
    bus.start = 1'b1;
    cyc("restart");
    clr();

    // ret on an empty stack (ignored without the stack).
    bus.pc = 4'h4; bus.ret_en = 1'b1;
    cyc("ret_empty");
    clr();
    bus.pc = 4'h2; bus.call_en = 1'b1; bus.target_addr = 4'h6;
    cyc("call_tgt6");
    clr();

    // Randomised run phase; halt held off.
    for (int i = 0; i < 400; i++) begin
      bus.start       = 1'($urandom_range(0, 1));
      bus.pc          = 4'($urandom_range(0, M - 1));
      bus.stall       = ($urandom_range(0, 4) == 0);
      bus.halt        = 1'b0;
      bus.branch_en   = ($urandom_range(0, 2) == 0);
      bus.branch_off  = 4'($urandom_range(0, M - 1));
      bus.jump_en     = ($urandom_range(0, 3) == 0);
      bus.call_en     = ($urandom_range(0, 3) == 0);
      bus.ret_en      = ($urandom_range(0, 3) == 0);
      bus.target_addr = 4'($urandom_range(0, M - 1));
      cyc("rand");
    end
    clr();

    // Halt is deferred by stall, then takes effect; start is ignored after.
    bus.pc = 4'h5; bus.halt = 1'b1; bus.stall = 1'b1; bus.jump_en = 1'b1;
    bus.target_addr = 4'hB;
    cyc("halt_stalled");
    bus.stall = 1'b0;
    cyc("halt");
    clr();
    bus.pc = 4'h7; bus.start = 1'b1; bus.call_en = 1'b1; bus.target_addr = 4'h1;
    cyc("halted_start");
    cyc("halted_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_sequencer
